// File: rtl/regdump_pkg.sv
// Shared constants and FSM state encoding for the register-file dump client.
// Build option: REGDUMP_CHECKSUM_EN adds a running XOR of dumped words.
package regdump_pkg;

    localparam int REGDUMP_NUM_REGS = 32;
    localparam int REGDUMP_ADDR_W   = 5;
    localparam int REGDUMP_DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks a wrapping address range through one regfile read port and streams
// (index, data, last) words out; REGDUMP_CHECKSUM_EN adds an XOR checksum.
//
// state | meaning
// IDLE  | waiting for start, raddr parked at 0
// RUN   | reading ptr and loading the output register when it is free
// DRAIN | final word loaded, waiting for the consumer to take it
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = REGDUMP_NUM_REGS,
    parameter int ADDR_W   = REGDUMP_ADDR_W,
    parameter int DATA_W   = REGDUMP_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_first_addr,
    input  logic [ADDR_W-1:0] i_last_addr,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_index,
    output logic              o_out_last,
    output logic              o_busy,
`ifdef REGDUMP_CHECKSUM_EN
    output logic [DATA_W-1:0] o_checksum,
    output logic              o_done
`else
    output logic              o_done
`endif
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_end;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_index;
    logic                r_out_last;
    logic                r_done;
    logic [ADDR_W-1:0]   w_raddr;
    logic [ADDR_W-1:0]   w_ptr_next;
    logic                w_load;

    assign w_load     = !r_out_valid || i_out_ready;
    assign w_ptr_next = ADDR_W'((32'(r_ptr) + 1) % NUM_REGS);

    always_comb begin
        w_raddr = '0;
        case (r_state)
            RUN:     w_raddr = r_ptr;
            DRAIN:   w_raddr = r_end;
            default: w_raddr = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_end       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // abort in the same cycle as start cancels the request
                    if (i_start && !i_abort) begin
                        r_ptr   <= i_first_addr;
                        r_end   <= i_last_addr;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_load) begin
                        r_out_data  <= i_rdata;
                        r_out_index <= r_ptr;
                        r_out_last  <= (r_ptr == r_end);
                        r_out_valid <= 1'b1;
                        r_ptr       <= w_ptr_next;
                        if (r_ptr == r_end) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (i_abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= IDLE;
                    end else if (r_out_valid && i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_checksum <= '0;
        end else if (r_state == IDLE && i_start && !i_abort) begin
            r_checksum <= '0;
        end else if (r_state != IDLE && !i_abort && r_out_valid && i_out_ready) begin
            r_checksum <= r_checksum ^ r_out_data;
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign o_raddr     = w_raddr;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_index = r_out_index;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Read-side client of the CPU register file. On request, it walks a contiguous, wrapping range of register addresses through one regfile read port.
- Each word read is streamed out over a valid/ready handshake as (index, data, last).
- Used by the debug/trace path to snapshot architectural state without stalling the write port.
- Regfile reads are combinational, and regfile writes land on the falling clock edge.

Parameters:
- NUM_REGS, 32, number of architectural registers; must be a power of two.
- ADDR_W, 5, register address width; equals log2(NUM_REGS).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  cancels a dump in progress.
- first_addr  input  ADDR_W  first register to dump; latched on start.
- last_addr  input  ADDR_W  final register to dump; latched on start.
- raddr  output  ADDR_W  regfile read-port address.
- rdata  input  DATA_W  regfile read data; combinational from raddr.
- out_valid  output  1  output word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  register contents.
- out_index  output  ADDR_W  register number of out_data.
- out_last  output  1  marks the final word of the dump.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: raddr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, state=IDLE. Reset takes effect immediately (asynchronous) and mid-dump drops all state with no done pulse.
- States are IDLE, RUN and DRAIN.
- IDLE:
  - raddr=0.
  - On start: ptr<=first_addr, end<=last_addr, go to RUN.
- RUN:
  - raddr=ptr combinationally.
  - Load condition is (!out_valid || out_ready). When it holds:
    - out_data<=rdata, out_index<=ptr, out_last<=(ptr==end), out_valid<=1.
    - ptr<=ptr+1 modulo NUM_REGS (31 wraps to 0).
  - Loading the word with ptr==end moves to DRAIN.
- DRAIN:
  - Holds raddr=end.
  - On out_valid && out_ready: out_valid<=0, out_last<=0, done<=1 for one cycle, go to IDLE.
- Handshake:
  - The word transfers on a rising edge where out_valid && out_ready.
  - With out_ready held high, throughput is one word per cycle.
  - While out_valid=1 and out_ready=0, out_data, out_index and out_last are stable.
- Latency: the first out_valid appears 2 cycles after the start edge (start edge -> RUN, then the load edge).
- Word count is ((last_addr-first_addr) mod NUM_REGS)+1:
  - first==last gives exactly 1 word.
  - first=last+1 gives all NUM_REGS words.
- Coherency: each word is the regfile value at the rising edge on which it is loaded, so any falling-edge write in the preceding half-cycle is included. No snapshot atomicity across the range.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins, stays in IDLE.
- abort in RUN or DRAIN: next edge clears out_valid and out_last, returns to IDLE, no done. A word not yet accepted is discarded.
- Register 0 reads as whatever the regfile returns (0); it is not special-cased.

Optional Feature:
- Macro REGDUMP_CHECKSUM_EN.
- Defined:
  - Adds output checksum (DATA_W).
  - Running XOR of every accepted out_data, cleared on start.
  - Final value is valid in the cycle done=1 and held until the next start.
  - Reset value 0.
  - abort leaves a partial value that is not meaningful.
- Undefined: no checksum port and no accumulator logic.

Decomposition:
- Package regdump_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - constants REGDUMP_NUM_REGS=32, REGDUMP_ADDR_W=5 and REGDUMP_DATA_W=32, shared with the regfile.
- No sub-module: pointer, FSM and output register are small enough to live in one module.

Test Plan:
- Preload regs 1..31 with 0x100+i. start with first=0, last=31, out_ready=1 -> 32 words, indices 0..31, data 0,0x101..0x11F. out_last only on index 31. done 1 cycle after that accept. busy low afterwards.
- first=30, last=2, out_ready=1 -> 5 words, indices 30,31,0,1,2. out_last on index 2.
- first=last=7, out_ready toggling 0/1 every cycle -> single word 0x107 held stable while ready=0. Exactly one transfer. One done pulse.
- Mid-dump write: regfile writes 0xDEADBEEF to reg 5 on the falling edge just before the reg-5 load edge -> out_data for index 5 is 0xDEADBEEF.
- abort asserted while out_valid=1 and out_ready=0 at index 4 (range 0..31) -> next edge out_valid=0, busy=0, done never pulses. A new start with first=0, last=0 then yields 1 word.
- Active-low reset asserted during RUN at index 10 -> outputs immediately 0 and state IDLE. With REGDUMP_CHECKSUM_EN, a 0..3 dump of 0,0x101,0x102,0x103 gives checksum 0x100.
